hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage ARM core (F/D/E/M/W).
- Keeps a shadow scoreboard of destination registers for instructions in E, M and W.
- From it, generates operand-forwarding selects, load-use stalls, branch flushes and PC-write drain sequencing.
- Drives the stall input of the decode stage and the stall/flush inputs of the other pipeline registers.

---
 rtl/hazard_pkg.sv | 44 ++++
 rtl/hazard_fwd_mux_sel.sv | 26 ++
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
// Holds the shadow-entry layout, forward-select codes and drain FSM states.
package hazard_pkg;

    // ARM has 16 architectural registers, so shadow entries carry 4-bit indices
    localparam int REG_IDX_W = 4;
    localparam logic [REG_IDX_W-1:0] PC_IDX = 4'd15;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic                 regwrite;
        logic                 memtoreg;
        logic                 pcwrite;
    } shadow_entry_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] ra1;
        logic [REG_IDX_W-1:0] ra2;
        logic [REG_IDX_W-1:0] rs;
        logic                 use1;
        logic                 use2;
        logic                 uses;
    } src_entry_t;

    // A consumed source (never r15, which reads the PC) produced by a live writer
    function automatic logic src_hit(input logic [REG_IDX_W-1:0] src,
                                     input logic                 used,
                                     input shadow_entry_t        e);
        return used && (src != PC_IDX) && e.valid && e.regwrite && (e.rd == src);
    endfunction

endpackage

// File: rtl/hazard_fwd_mux_sel.sv
// Forward select for one E-stage operand: the younger writer in M wins
// over the older one in W; otherwise the register file value is used.
module hazard_fwd_mux_sel
    import hazard_pkg::*;
(
    input  logic [REG_IDX_W-1:0] src,
    input  logic                 src_used,
    input  shadow_entry_t        m_entry,
    input  shadow_entry_t        w_entry,
    output fwd_sel_e             sel
);

    logic unused_bits;
    assign unused_bits = ^{m_entry.memtoreg, m_entry.pcwrite,
                           w_entry.memtoreg, w_entry.pcwrite};

    always_comb begin
        sel = FWD_RF;
        if (src_hit(src, src_used, m_entry)) begin
            sel = FWD_M;
        end else if (src_hit(src, src_used, w_entry)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow scoreboard of E/M/W destinations driving
// operand forwarding, load-use stalls, branch flushes and PC-write drain.
//
// state    | meaning
// ST_RUN   | normal issue; load-use stalls and branch flushes only
// ST_DRAIN | PC writer has left D; hold F and bubble D until it retires
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REGW      = REG_IDX_W,
    parameter int DRAIN_CYC = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] RA1D,
    input  logic [REGW-1:0] RA2D,
    input  logic [REGW-1:0] RsD,
    input  logic            UseRA1D,
    input  logic            UseRA2D,
    input  logic            UseRsD,
    input  logic [REGW-1:0] RdD,
    input  logic            RegWriteD,
    input  logic            MemtoRegD,
    input  logic            PCSrcD,
    input  logic            CondExE,
    input  logic            BranchTakenE,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD,
    output logic            FlushE,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic [1:0]      ForwardSE
);

    localparam int CW = $clog2(DRAIN_CYC + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DRAIN_CYC);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    shadow_entry_t e_q, m_q, w_q;
    src_entry_t    src_q;

    logic     ldstall;
    logic     stall_f, stall_d, flush_d, flush_e;
    fwd_sel_e fwd_a, fwd_b, fwd_s;

    hazard_fwd_mux_sel u_fwd_a (
        .src(src_q.ra1), .src_used(src_q.use1), .m_entry(m_q), .w_entry(w_q), .sel(fwd_a)
    );
    hazard_fwd_mux_sel u_fwd_b (
        .src(src_q.ra2), .src_used(src_q.use2), .m_entry(m_q), .w_entry(w_q), .sel(fwd_b)
    );
    hazard_fwd_mux_sel u_fwd_s (
        .src(src_q.rs), .src_used(src_q.uses), .m_entry(m_q), .w_entry(w_q), .sel(fwd_s)
    );

    always_comb begin
        ldstall = e_q.memtoreg && CondExE &&
                  (src_hit(RA1D, UseRA1D, e_q) ||
                   src_hit(RA2D, UseRA2D, e_q) ||
                   src_hit(RsD,  UseRsD,  e_q));

        stall_f  = 1'b0;
        stall_d  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        state_nx = state;
        cnt_nx   = cnt;

        // A taken branch squashes D, so a pending load-use or drain is moot
        if (BranchTakenE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (state == ST_DRAIN) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
        end else if (ldstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end

        case (state)
            ST_RUN: begin
                if (PCSrcD && !stall_d && !flush_d) begin
                    state_nx = ST_DRAIN;
                    cnt_nx   = CNT_LOAD;
                end
            end
            ST_DRAIN: begin
                if (BranchTakenE || (e_q.valid && e_q.pcwrite && !CondExE) ||
                    (cnt == CNT_ONE)) begin
                    state_nx = ST_RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nx = ST_RUN;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
            cnt   <= '0;
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            src_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            w_q   <= m_q;
            m_q   <= '{valid:    e_q.valid,
                       rd:       e_q.rd,
                       regwrite: e_q.regwrite && CondExE,
                       memtoreg: e_q.memtoreg,
                       pcwrite:  e_q.pcwrite && CondExE};
            if (flush_e || stall_d) begin
                e_q   <= '0;
                src_q <= '0;
            end else begin
                e_q   <= '{valid: 1'b1, rd: RdD, regwrite: RegWriteD,
                           memtoreg: MemtoRegD, pcwrite: PCSrcD};
                src_q <= '{ra1: RA1D, ra2: RA2D, rs: RsD,
                           use1: UseRA1D, use2: UseRA2D, uses: UseRsD};
            end
        end
    end

    // Reset dominates: outputs are quiet while it is held
    assign StallF    = stall_f && !reset;
    assign StallD    = stall_d && !reset;
    assign FlushD    = flush_d && !reset;
    assign FlushE    = flush_e && !reset;
    assign ForwardAE = reset ? 2'b00 : fwd_a;
    assign ForwardBE = reset ? 2'b00 : fwd_b;
    assign ForwardSE = reset ? 2'b00 : fwd_s;

endmodule
